pc_fetch_unit: RTL

- Program-counter register and fetch sequencer; the consumer of the PC adder.
- Drives pc_o into the PC adder's operand input and takes back the adder's sum on pc_plus4_i.
- Issues instruction-fetch requests over a valid/ready handshake.
- Advances the PC, holds it on a stall, or loads a redirect target from branch/jump logic.

---
 rtl/pc_fetch_unit.sv | 106 ++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Program-counter register and fetch sequencer: issues valid/ready fetch requests and steps, holds or redirects the PC.
// Optional MISALIGN_TRAP_EN: a misaligned redirect enters a TRAP state at TRAP_VEC until trap_clear_i.
module pc_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_plus4_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            fetch_ready_i,
    input  logic            trap_clear_i,
    output logic [XLEN-1:0] pc_o,
    output logic            fetch_valid_o,
    output logic            flush_o,
    output logic [31:0]     fetch_count_o,
    output logic            trap_o
);

    typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

    state_t state;
    logic   handshake;

    assign fetch_valid_o = (state == RUN) && !stall_i;
    assign handshake     = fetch_valid_o && fetch_ready_i;

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (redirect_pc_i[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= BOOT;
            pc_o          <= RESET_PC;
            flush_o       <= 1'b0;
            fetch_count_o <= '0;
            trap_o        <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    // A handshake in the redirect cycle is still counted; downstream drops it on flush.
                    if (handshake) fetch_count_o <= fetch_count_o + 32'd1;
                    flush_o <= redirect_i;
                    if (redirect_i) begin
                        if (misaligned) begin
                            pc_o   <= TRAP_VEC;
                            trap_o <= 1'b1;
                            state  <= TRAP;
                        end else begin
                            pc_o <= redirect_pc_i;
                        end
                    end else if (handshake) begin
                        pc_o <= pc_plus4_i;
                    end
                end
                TRAP: begin
                    flush_o <= 1'b0;
                    if (trap_clear_i) begin
                        trap_o <= 1'b0;
                        state  <= RUN;
                    end
                end
                default: begin
                    flush_o <= 1'b0;
                    state   <= RUN;
                end
            endcase
        end
    end
`else
    logic unused_trap_inputs;
    assign unused_trap_inputs = trap_clear_i ^ (^TRAP_VEC) ^ (^redirect_pc_i[1:0]);
    assign trap_o = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= BOOT;
            pc_o          <= RESET_PC;
            flush_o       <= 1'b0;
            fetch_count_o <= '0;
        end else begin
            case (state)
                RUN: begin
                    // A handshake in the redirect cycle is still counted; downstream drops it on flush.
                    if (handshake) fetch_count_o <= fetch_count_o + 32'd1;
                    flush_o <= redirect_i;
                    if (redirect_i) begin
                        pc_o <= {redirect_pc_i[XLEN-1:2], 2'b00};
                    end else if (handshake) begin
                        pc_o <= pc_plus4_i;
                    end
                end
                default: begin
                    flush_o <= 1'b0;
                    state   <= RUN;
                end
            endcase
        end
    end
`endif

endmodule
